// File: rtl/fluid_fixed_pkg.sv
// Shared fixed-point definitions for the fluid velocity path: default word
// format, saturation constant and the magnitude-squared feeder state encoding.
package fluid_fixed_pkg;

    localparam int FIX_WIDTH = 32;
    localparam int FIX_FBITS = 16;

    // Largest radicand the sqrt stage accepts; used when vx^2+vy^2 overflows.
    localparam logic [FIX_WIDTH-1:0] SAT_MAX = {FIX_WIDTH{1'b1}};

    typedef logic signed [FIX_WIDTH-1:0] fix_t;

    typedef enum logic [2:0] {
        IDLE,
        SQ_X,
        SQ_Y,
        SUM,
        ISSUE,
        WAIT
    } feed_state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Unsigned WIDTH x WIDTH sequential shift-add multiplier, one multiplier bit
// per clock. The load cycle already retires bit 0, so the product is ready
// (done high) WIDTH-1 edges after the loading edge. The caller sequences it.
module mul_shift_add
    import fluid_fixed_pkg::*;
#(
    parameter int WIDTH = FIX_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    // Upper half accumulates partial sums, lower half holds the unconsumed
    // multiplier bits; each step adds the multiplicand if the LSB is set and
    // shifts the whole register right by one.
    logic [2*WIDTH-1:0] p_reg, p_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [CW-1:0]      cnt_reg, cnt_next;

    function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                                input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] hi;
        hi = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {hi, p[WIDTH-1:1]};
    endfunction

    // Next-state: load performs the first step, then keep stepping until the count runs out.
    always_comb begin
        p_next   = p_reg;
        a_next   = a_reg;
        cnt_next = cnt_reg;
        if (load) begin
            p_next   = step({{WIDTH{1'b0}}, b}, a);
            a_next   = a;
            cnt_next = LAST_STEP;
        end else if (cnt_reg != '0) begin
            p_next   = step(p_reg, a_reg);
            cnt_next = cnt_reg - CW'(1);
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg   <= '0;
            a_reg   <= '0;
            cnt_reg <= '0;
        end else begin
            p_reg   <= p_next;
            a_reg   <= a_next;
            cnt_reg <= cnt_next;
        end
    end

    assign prod = p_reg;
    assign done = (cnt_reg == '0);

endmodule

// File: rtl/vec_mag_sq_feed.sv
// Computes the saturated magnitude-squared of a signed 2-D velocity sample
// using one shared sequential multiplier, then hands the radicand to the
// downstream sqrt stage with a start pulse and waits for its done pulse.
module vec_mag_sq_feed
    import fluid_fixed_pkg::*;
#(
    parameter int WIDTH = FIX_WIDTH,
    parameter int FBITS = FIX_FBITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] vx,
    input  logic signed [WIDTH-1:0] vy,
    output logic                    sqrt_start,
    output logic [WIDTH-1:0]        sqrt_rad,
    input  logic                    sqrt_done,
    output logic                    busy,
    output logic                    sat
);

    feed_state_t state_reg, state_next;

    logic [WIDTH-1:0]   ay_reg;
    logic [2*WIDTH-1:0] sqx_reg, sqy_reg;
    logic [WIDTH-1:0]   rad_reg;
    logic               sat_reg;

    logic               mul_load;
    logic [WIDTH-1:0]   mul_op;
    logic [2*WIDTH-1:0] mul_prod;
    logic               mul_done;

    // Magnitudes of both components; negating the most negative value wraps
    // to 2^(WIDTH-1), which is exactly right when read as unsigned.
    logic [WIDTH-1:0] comp_in  [2];
    logic [WIDTH-1:0] comp_abs [2];
    assign comp_in[0] = vx;
    assign comp_in[1] = vy;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_abs
            assign comp_abs[gi] = comp_in[gi][WIDTH-1] ? -comp_in[gi] : comp_in[gi];
        end
    endgenerate

    // Squares are already scaled back by FBITS, so their sum fits in 2*WIDTH+1 bits.
    logic [2*WIDTH:0] sum_w;
    logic             sum_sat;
    assign sum_w   = {1'b0, sqx_reg} + {1'b0, sqy_reg};
    assign sum_sat = |sum_w[2*WIDTH:WIDTH];

    // The x operand goes straight from the input port on the accepting edge;
    // y was latched then and is fed once the x square is stored.
    assign mul_op = (state_reg == IDLE) ? comp_abs[0] : ay_reg;

    mul_shift_add #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (mul_load),
        .a     (mul_op),
        .b     (mul_op),
        .prod  (mul_prod),
        .done  (mul_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic; sqrt_done is only meaningful while waiting.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = SQ_X;
            SQ_X:    if (mul_done) state_next = SQ_Y;
            SQ_Y:    if (mul_done) state_next = SUM;
            SUM:     state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (sqrt_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output and multiplier-control decode from the current state.
    always_comb begin
        in_ready   = (state_reg == IDLE);
        busy       = (state_reg != IDLE);
        sqrt_start = (state_reg == ISSUE);
        mul_load   = ((state_reg == IDLE) && in_valid) ||
                     ((state_reg == SQ_X) && mul_done);
    end

    // Datapath: latch |vy| on accept, capture each scaled square, then form the radicand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ay_reg  <= '0;
            sqx_reg <= '0;
            sqy_reg <= '0;
            rad_reg <= '0;
            sat_reg <= 1'b0;
        end else begin
            if ((state_reg == IDLE) && in_valid)
                ay_reg <= comp_abs[1];
            if ((state_reg == SQ_X) && mul_done)
                sqx_reg <= mul_prod >> FBITS;
            if ((state_reg == SQ_Y) && mul_done)
                sqy_reg <= mul_prod >> FBITS;
            if (state_reg == SUM) begin
                rad_reg <= sum_sat ? {WIDTH{1'b1}} : sum_w[WIDTH-1:0];
                sat_reg <= sum_sat;
            end
        end
    end

    assign sqrt_rad = rad_reg;
    assign sat      = sat_reg;

endmodule

// File: tb/tb_vec_mag_sq_feed.sv
// Scoreboard bench for vec_mag_sq_feed with a behavioural sqrt-stage partner.
module tb_vec_mag_sq_feed;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] vx = '0;
    logic signed [31:0] vy = '0;
    logic               sqrt_start;
    logic [31:0]        sqrt_rad;
    logic               sqrt_done = 1'b0;
    logic               busy;
    logic               sat;

    vec_mag_sq_feed #(
        .WIDTH (32),
        .FBITS (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .vx         (vx),
        .vy         (vy),
        .sqrt_start (sqrt_start),
        .sqrt_rad   (sqrt_rad),
        .sqrt_done  (sqrt_done),
        .busy       (busy),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rad;
        logic        sat;
        int          acc;
    } exp_t;

    exp_t q[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_start = 0;
    int outstanding = 0;

    // sqrt-stage model controls
    bit          active = 0;
    bit          chk_ready = 0;
    bit          stray_req = 0;
    bit          glitch_en = 0;
    int          delay_min = 0;
    int          wait_cnt = 0;
    logic [31:0] cur_rad = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: magnitude-squared straight from the arithmetic definition.
    function automatic logic [32:0] ref_model(input logic [31:0] x, input logic [31:0] y);
        longint unsigned ax, ay, s;
        ax = x[31] ? (64'h1_0000_0000 - {32'h0, x}) : {32'h0, x};
        ay = y[31] ? (64'h1_0000_0000 - {32'h0, y}) : {32'h0, y};
        s  = ((ax * ax) >> 16) + ((ay * ay) >> 16);
        if (s >= 64'h1_0000_0000) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, s[31:0]};
    endfunction

    // Accept observer: record expectation for every handshake.
    always @(posedge clk) begin
        logic [32:0] r;
        cyc = cyc + 1;
        if (rst_n && in_valid && in_ready) begin
            r = ref_model(vx, vy);
            q.push_back('{rad: r[31:0], sat: r[32], acc: cyc});
            n_acc++;
            chk("accept_while_busy", 64'(outstanding), 64'd0);
            outstanding = 1;
            $display("accept  cyc=%0d vx=%h vy=%h exp_rad=%h exp_sat=%0d", cyc, vx, vy, r[31:0], r[32]);
        end
    end

    // Monitor + sqrt-stage model, evaluated on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        sqrt_done = 1'b0;
        if (!rst_n) begin
            chk("reset_outputs", {59'd0, in_ready, busy, sqrt_start, sat, 1'b0},
                {59'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
            chk("reset_rad", 64'(sqrt_rad), 64'd0);
            q.delete();
            active = 0;
            chk_ready = 0;
            outstanding = 0;
        end else begin
            if (chk_ready) begin
                chk("ready_after_done", {62'd0, in_ready, busy}, {62'd0, 1'b1, 1'b0});
                chk_ready = 0;
            end
            if (sqrt_start) begin
                n_start++;
                if (q.size() == 0) begin
                    chk("start_unexpected", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("rad", 64'(sqrt_rad), 64'(e.rad));
                    chk("sat", 64'(sat), 64'(e.sat));
                    chk("start_latency", 64'(cyc - e.acc), 64'd65);
                    $display("start   cyc=%0d rad=%h sat=%0d exp_rad=%h exp_sat=%0d", cyc, sqrt_rad, sat, e.rad, e.sat);
                    cur_rad = e.rad;
                end
                active = 1;
                wait_cnt = delay_min + $urandom_range(0, 6);
                if (glitch_en && ($urandom_range(0, 1) == 1)) sqrt_done = 1'b1;
            end else if (active) begin
                chk("wait_hold", {30'd0, busy, in_ready, sqrt_rad}, {30'd0, 1'b1, 1'b0, cur_rad});
                if (wait_cnt == 0) begin
                    sqrt_done = 1'b1;
                    active = 0;
                    chk_ready = 1;
                    outstanding = 0;
                end else begin
                    wait_cnt--;
                end
            end else if (stray_req) begin
                sqrt_done = 1'b1;
                stray_req = 0;
                chk_ready = 1;
            end
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y);
        int a0;
        bit ok;
        a0 = n_acc;
        ok = 0;
        @(negedge clk);
        in_valid = 1'b1;
        vx = x;
        vy = y;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (n_acc != a0) ok = 1;
        end
        in_valid = 1'b0;
        chk("send_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0 && !active && !chk_ready && in_ready) ok = 1;
        end
        chk("idle_timeout", 64'(ok), 64'd1);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rx, ry;
        bit ok;
        int a0;

        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Directed samples
        send(32'h0003_0000, 32'h0004_0000); wait_idle();
        send(32'hFFFD_0000, 32'hFFFC_0000); wait_idle();
        send(32'h7FFF_FFFF, 32'h0000_0000); wait_idle();
        send(32'h0001_0000, 32'h0000_0000); wait_idle();
        send(32'h0000_0000, 32'h0000_0000); wait_idle();
        send(32'h8000_0000, 32'h8000_0000); wait_idle();
        send(32'h00B5_0000, 32'hFF4B_0000); wait_idle();

        // Random samples, with occasional done pulses during ISSUE
        glitch_en = 1;
        for (int i = 0; i < 12; i++) begin
            rx = $urandom;
            ry = $urandom;
            rx = 32'($signed(rx) >>> $urandom_range(0, 24));
            ry = 32'($signed(ry) >>> $urandom_range(0, 24));
            send(rx, ry);
            wait_idle();
        end
        glitch_en = 0;

        // in_valid held high with fresh data every cycle
        a0 = n_acc;
        in_valid = 1'b1;
        for (int i = 0; i < 3000 && (n_acc - a0) < 4; i++) begin
            @(negedge clk);
            vx = 32'($signed($urandom) >>> $urandom_range(8, 20));
            vy = 32'($signed($urandom) >>> $urandom_range(8, 20));
        end
        in_valid = 1'b0;
        chk("hold_accepts", 64'(n_acc - a0), 64'd4);
        wait_idle();

        // Reset during SQ_Y
        send(32'h0002_0000, 32'h0002_0000);
        repeat (40) @(negedge clk);
        reset_pulse();
        // Stray done while idle
        stray_req = 1;
        repeat (4) @(negedge clk);
        chk("stray_ignored", {62'd0, in_ready, busy}, {62'd0, 1'b1, 1'b0});

        // Reset during WAIT
        delay_min = 40;
        send(32'h0006_0000, 32'h0008_0000);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (active) ok = 1;
        end
        chk("reach_wait", 64'(ok), 64'd1);
        repeat (5) @(negedge clk);
        reset_pulse();
        delay_min = 0;
        stray_req = 1;
        repeat (4) @(negedge clk);

        // Reset in the ISSUE cycle
        send(32'h0001_8000, 32'h0002_8000);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (sqrt_start) ok = 1;
        end
        chk("reach_issue", 64'(ok), 64'd1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Recovery sample
        send(32'h0001_8000, 32'hFFFD_8000); wait_idle();
        send(32'h0003_0000, 32'h0004_0000); wait_idle();

        chk("queue_empty", 64'(q.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
